// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_pkg
// Description : Shared types and helpers for the bin2bcd converter: FSM
//               state encoding and the BCD output width function.
// Revision    : 1.0 - initial release
// ============================================================================
package bin2bcd_pkg;

  // Converter FSM states, explicitly encoded in two bits
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of BCD output bits needed to hold any w-bit unsigned value
  function automatic int bcd_width(input int w);
    return w + (w - 4) / 3 + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_digit.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_digit
// Description : One double-dabble correction cell. Adds 3 to a BCD digit
//               that is 5 or more so the following left shift carries
//               correctly into the next decimal digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Pre-shift correction: digits 5..9 become 8..12
  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule
`default_nettype wire

// File: rtl/bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd
// Description : Sequential shift-add-3 (double-dabble) binary to packed BCD
//               converter. One conversion takes W+2 cycles: accept, W
//               shift cycles, and a result/handshake cycle.
//               Compile-time option: define BIN2BCD_ERR_EN to add the err
//               output flagging start requests made while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd
  import bin2bcd_pkg::*;
#(
  parameter  int W  = 8,
  localparam int BW = bcd_width(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  bin,
  output logic          ready,
  output logic          done_tick,
  output logic [BW-1:0] bcd
`ifdef BIN2BCD_ERR_EN
  ,
  output logic          err
`endif
);

  // Accumulator is kept in whole digits; the top digit is only partly
  // exported on bcd, its unused bits are always zero.
  localparam int c_ND = (BW + 3) / 4;
  localparam int c_AW = 4 * c_ND;
  localparam int c_CW = $clog2(W + 1);
  localparam logic [c_CW-1:0] c_ONE   = c_CW'(1);
  localparam logic [c_CW-1:0] c_SHIFT = c_CW'(W);

  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_sr;
  logic [c_AW-1:0]   r_acc;
  logic [c_AW-1:0]   w_adj;
  logic [c_CW-1:0]   r_cnt;
  logic [BW-1:0]     r_bcd;
  logic              r_done;
  logic              w_load;
  logic              w_shift;
  logic              w_finish;

  // One correction cell per accumulator digit
  for (genvar k = 0; k < c_ND; k++) begin : g_digit
    bin2bcd_digit u_digit (
      .din  (r_acc[4*k +: 4]),
      .dout (w_adj[4*k +: 4])
    );
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: leave OP on the cycle performing the last shift
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = OP;
      OP:      if (r_cnt == c_ONE) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    ready    = (r_state == IDLE);
    w_load   = (r_state == IDLE) && start;
    w_shift  = (r_state == OP);
    w_finish = (r_state == DONE);
  end

  // Datapath: capture operand, shift-add-3 per cycle, publish result in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_sr  <= bin;
        r_acc <= '0;
        r_cnt <= c_SHIFT;
      end else if (w_shift) begin
        r_sr  <= r_sr << 1;
        r_acc <= (w_adj << 1) | c_AW'(r_sr[W-1]);
        r_cnt <= r_cnt - c_ONE;
      end
      if (w_finish) r_bcd <= r_acc[BW-1:0];
    end
  end

  assign done_tick = r_done;
  assign bcd       = r_bcd;

`ifdef BIN2BCD_ERR_EN
  logic r_err;

  // Flag a start request that arrives while a conversion is in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= start & ~ready;
  end

  assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd
// Description : Scoreboard testbench for bin2bcd (W=8 and W=16 instances).
//               Drivers push expected results; monitors pop on done_tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        start  = 1'b0;
  logic [7:0]  bin    = '0;
  logic        ready;
  logic        done_tick;
  logic [9:0]  bcd;

  logic        start16 = 1'b0;
  logic [15:0] bin16   = '0;
  logic        ready16;
  logic        done16;
  logic [20:0] bcd16;

`ifdef BIN2BCD_ERR_EN
  logic        err;
  logic        err16;
`endif

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [23:0] val;
    int          scyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];

  bin2bcd #(.W(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
`ifdef BIN2BCD_ERR_EN
    ,
    .err       (err)
`endif
  );

  bin2bcd #(.W(16)) u_dut16 (
    .clk       (clk),
    .reset     (reset),
    .start     (start16),
    .bin       (bin16),
    .ready     (ready16),
    .done_tick (done16),
    .bcd       (bcd16)
`ifdef BIN2BCD_ERR_EN
    ,
    .err       (err16)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the W=8 instance
  logic prev_done8 = 1'b0;
  always @(negedge clk) begin : mon8
    exp_t e;
    if (done_tick) begin
      chk("done8_single_cycle", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) begin
        chk("done8_unexpected", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("bcd8", {22'd0, bcd}, {8'd0, e.val});
        chk("latency8", cyc - e.scyc, 32'd9);
        for (int k = 0; k < 2; k++)
          chk("digit8_le9", {31'd0, (bcd[4*k +: 4] > 4'd9)}, 32'd0);
      end
    end
    prev_done8 = done_tick;
  end

  // Monitor for the W=16 instance
  logic prev_done16 = 1'b0;
  always @(negedge clk) begin : mon16
    exp_t e;
    if (done16) begin
      chk("done16_single_cycle", {31'd0, prev_done16}, 32'd0);
      if (q16.size() == 0) begin
        chk("done16_unexpected", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        chk("bcd16", {11'd0, bcd16}, {8'd0, e.val});
        chk("latency16", cyc - e.scyc, 32'd17);
        chk("bcd16_upper_zero", {30'd0, bcd16[20:19]}, 32'd0);
        for (int k = 0; k < 5; k++)
          chk("digit16_le9", {31'd0, (bcd16[4*k +: 4] > 4'd9)}, 32'd0);
      end
    end
    prev_done16 = done16;
  end

  // One W=8 conversion; optional busy start, operand change and hold check
  task automatic conv8(input logic [7:0] v, input logic [9:0] expv,
                       input int busy_at, input int chg_at,
                       input logic hold_chk, input logic [9:0] hold);
    exp_t e;
    @(negedge clk);
    bin    = v;
    start  = 1'b1;
    e.val  = {14'd0, expv};
    e.scyc = cyc + 1;
    q8.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = (i == busy_at);
      if (i == chg_at) bin = 8'd7;
`ifdef BIN2BCD_ERR_EN
      chk("err8", {31'd0, err}, {31'd0, (busy_at >= 0 && i == busy_at + 1)});
`endif
      if (hold_chk && !done_tick) chk("hold8", {22'd0, bcd}, {22'd0, hold});
      if (ready) begin
        start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    chk("timeout8", 32'd1, 32'd0);
  endtask

  initial begin : main
    exp_t e;
    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ready8", {31'd0, ready}, 32'd1);
    chk("reset_done8", {31'd0, done_tick}, 32'd0);
    chk("reset_bcd8", {22'd0, bcd}, 32'd0);
    chk("reset_ready16", {31'd0, ready16}, 32'd1);
    chk("reset_bcd16", {11'd0, bcd16}, 32'd0);
`ifdef BIN2BCD_ERR_EN
    chk("reset_err8", {31'd0, err}, 32'd0);
`endif
    reset = 1'b0;

    // Basic sequential conversions
    conv8(8'd0,   10'h000, -1, -1, 1'b1, 10'h000);
    conv8(8'd1,   10'h001, -1, -1, 1'b1, 10'h000);
    conv8(8'd12,  10'h012, -1, -1, 1'b1, 10'h001);
    conv8(8'd25,  10'h025, -1, -1, 1'b1, 10'h012);
    // Operand change during OP must not matter; old result held
    conv8(8'd98,  10'h098, -1,  2, 1'b1, 10'h025);
    // Busy-time start ignored; previous result held during OP
    conv8(8'd129, 10'h129,  3, -1, 1'b1, 10'h098);

    // Reset mid-conversion: aborted, bcd cleared, no done_tick
    @(negedge clk);
    bin   = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_bcd", {22'd0, bcd}, 32'd0);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_done", {31'd0, done_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_no_pending", q8.size(), 32'd0);

    // First conversion after reset, then upper corner cases
    conv8(8'd200, 10'h200, -1, -1, 1'b1, 10'h000);
    conv8(8'd255, 10'h255, -1, -1, 1'b1, 10'h200);

    // W=16 all-ones
    @(negedge clk);
    bin16   = 16'hFFFF;
    start16 = 1'b1;
    e.val   = 24'h065535;
    e.scyc  = cyc + 1;
    q16.push_back(e);
    @(posedge clk);
    #1 start16 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready16) break;
    end
    if (!ready16) chk("timeout16", 32'd1, 32'd0);

    repeat (3) @(negedge clk);
    chk("q8_drained", q8.size(), 32'd0);
    chk("q16_drained", q16.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
